// File: rtl/led_blinker_array.sv
// Multi-channel LED blinker: shared 1 ms prescaler, per-channel OFF/ON/BLINK/BURST modes.
// Config writes are applied in the following cycle; cfg_ready only drops during reset. led and burst_done are registered.
module led_blinker_array #(
  parameter int CLK_FREQ_KHz    = 50000,
  parameter int CHANNELS        = 4,
  parameter int CNT_W           = 16,
  parameter int BURST_W         = 4,
  parameter int DEFAULT_HALF_MS = 500,
  localparam int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_half_ms,
  input  logic [BURST_W-1:0]  cfg_burst,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] burst_done
);

  localparam int PS_W  = (CLK_FREQ_KHz > 1) ? $clog2(CLK_FREQ_KHz) : 1;
  localparam int REM_W = BURST_W + 1;
  localparam logic [CNT_W-1:0] RST_HALF =
      (DEFAULT_HALF_MS == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF_MS);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  logic [PS_W-1:0]  ps_cnt;
  logic             tick;
  logic             wr_en;
  logic [CNT_W-1:0] cfg_half_eff;
  logic [REM_W-1:0] burst_load;

  mode_e            mode     [CHANNELS];
  logic [CNT_W-1:0] half     [CHANNELS];
  logic [CNT_W-1:0] cnt      [CHANNELS];
  logic [CNT_W-1:0] last_cnt [CHANNELS];
  logic [REM_W-1:0] rem      [CHANNELS];

  assign cfg_ready    = ~rst;
  assign wr_en        = cfg_valid & cfg_ready & (32'(cfg_ch) < CHANNELS);
  assign tick         = (ps_cnt == PS_W'(CLK_FREQ_KHz - 1));
  // A zero half-period is stored as 1 so the expiry compare never underflows.
  assign cfg_half_eff = (cfg_half_ms == '0) ? CNT_W'(1) : cfg_half_ms;
  assign burst_load   = {cfg_burst, 1'b0} - REM_W'(1);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      last_cnt[i] = half[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        mode[i]       <= MODE_BLINK;
        half[i]       <= RST_HALF;
        cnt[i]        <= '0;
        rem[i]        <= '0;
        led[i]        <= 1'b1;
        burst_done[i] <= 1'b0;
      end else if (wr_en && (cfg_ch == CH_W'(i))) begin
        // A write wins over a coincident tick: the channel restarts its period.
        half[i]       <= cfg_half_eff;
        cnt[i]        <= '0;
        rem[i]        <= burst_load;
        burst_done[i] <= 1'b0;
        case (mode_e'(cfg_mode))
          MODE_OFF: begin
            mode[i] <= MODE_OFF;
            led[i]  <= 1'b0;
          end
          MODE_ON: begin
            mode[i] <= MODE_ON;
            led[i]  <= 1'b1;
          end
          MODE_BLINK: begin
            mode[i] <= MODE_BLINK;
            led[i]  <= 1'b1;
          end
          MODE_BURST: begin
            if (cfg_burst == '0) begin
              mode[i]       <= MODE_OFF;
              led[i]        <= 1'b0;
              burst_done[i] <= 1'b1;
            end else begin
              mode[i] <= MODE_BURST;
              led[i]  <= 1'b1;
            end
          end
        endcase
      end else begin
        burst_done[i] <= 1'b0;
        if (tick && (mode[i] == MODE_BLINK || mode[i] == MODE_BURST)) begin
          if (cnt[i] == last_cnt[i]) begin
            cnt[i] <= '0;
            if (mode[i] == MODE_BURST && rem[i] == REM_W'(1)) begin
              mode[i]       <= MODE_OFF;
              led[i]        <= 1'b0;
              burst_done[i] <= 1'b1;
            end else begin
              led[i] <= ~led[i];
              if (mode[i] == MODE_BURST) begin
                rem[i] <= rem[i] - REM_W'(1);
              end
            end
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_blinker_array.sv
// Bench for led_blinker_array: directed scenarios with literal expectations plus randomized writes/resets vs a tick-countdown model.
module tb_led_blinker_array;

  localparam int K   = 4;
  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int BW  = 4;
  localparam int DEF = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_ch = '0;
  logic [1:0]    cfg_mode = '0;
  logic [CW-1:0] cfg_half_ms = '0;
  logic [BW-1:0] cfg_burst = '0;
  logic [NCH-1:0] led;
  logic [NCH-1:0] burst_done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // Model: cycles since reset, per-channel ticks-until-expiry and toggles left.
  int m_n;
  int m_mode [NCH];
  int m_half [NCH];
  int m_left [NCH];
  int m_tog  [NCH];
  bit [NCH-1:0] m_led;
  bit [NCH-1:0] m_done;

  always #5 clk = ~clk;

  led_blinker_array #(
    .CLK_FREQ_KHz(K), .CHANNELS(NCH), .CNT_W(CW), .BURST_W(BW), .DEFAULT_HALF_MS(DEF)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half_ms(cfg_half_ms), .cfg_burst(cfg_burst),
    .led(led), .burst_done(burst_done)
  );

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_step();
    bit tick;
    if (rst) begin
      m_n = 0;
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 2; m_half[i] = DEF; m_left[i] = DEF; m_tog[i] = 0;
        m_led[i] = 1'b1; m_done[i] = 1'b0;
      end
    end else begin
      tick = ((m_n % K) == K - 1);
      m_n++;
      for (int i = 0; i < NCH; i++) begin
        m_done[i] = 1'b0;
        if (cfg_valid && int'(cfg_ch) == i) begin
          m_half[i] = (cfg_half_ms == 0) ? 1 : int'(cfg_half_ms);
          m_left[i] = m_half[i];
          m_tog[i]  = 2 * int'(cfg_burst) - 1;
          m_mode[i] = int'(cfg_mode);
          m_led[i]  = (cfg_mode != 0);
          if (cfg_mode == 3 && cfg_burst == 0) begin
            m_led[i] = 1'b0; m_done[i] = 1'b1; m_mode[i] = 0;
          end
        end else if (tick && (m_mode[i] == 2 || m_mode[i] == 3)) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_left[i] = m_half[i];
            if (m_mode[i] == 3 && m_tog[i] == 1) begin
              m_led[i] = 1'b0; m_done[i] = 1'b1; m_mode[i] = 0;
            end else begin
              m_led[i] = ~m_led[i];
              m_tog[i]--;
            end
          end
        end
      end
    end
  endtask

  // The per-cycle compare point: advance DUT and model together, then compare.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("led", int'(led), int'(m_led));
    check("burst_done", int'(burst_done), int'(m_done));
    check("cfg_ready", int'(cfg_ready), rst ? 0 : 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cfg_valid = 1'b0;
    repeat (n) step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic write(input int ch, input int mode, input int half, input int burst);
    cfg_valid   = 1'b1;
    cfg_ch      = 2'(ch);
    cfg_mode    = 2'(mode);
    cfg_half_ms = CW'(half);
    cfg_burst   = BW'(burst);
    step();
    cfg_valid = 1'b0;
  endtask

  function automatic int pat030(input int c);
    return ((c / 8) % 2 == 0) ? 1 : 0;
  endfunction

  initial begin
    // Reset release, default blinking.
    do_reset(2);
    check("rst_led", int'(led), 7);
    check("rst_done", int'(burst_done), 0);
    while (cyc < 24) begin
      step();
      check("default_blink", int'(led), pat030(cyc) ? 7 : 0);
    end

    // Channel 1 forced ON at cycle 1.
    do_reset(1);
    step();
    write(1, 1, 0, 0);
    for (int k = 0; k < 40; k++) begin
      check("on_led1", int'(led[1]), 1);
      check("on_led0", int'(led[0]), pat030(cyc));
      check("on_led2", int'(led[2]), pat030(cyc));
      step();
    end

    // Burst of two pulses with half=1.
    do_reset(1);
    write(2, 3, 1, 2);
    while (cyc < 30) begin
      check("burst_led2", int'(led[2]), (cyc < 4) ? 1 : (cyc < 8) ? 0 : (cyc < 12) ? 1 : 0);
      check("burst_done2", int'(burst_done[2]), (cyc == 12) ? 1 : 0);
      step();
    end

    // Out-of-range channel write is ignored.
    do_reset(1);
    while (cyc < 9) step();
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_mode = 2'd1;
    #1;
    check("oob_ready", int'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    while (cyc < 16) begin
      check("oob_led", int'(led), 0);
      step();
    end

    // Reset mid-burst restarts default timing.
    do_reset(1);
    write(2, 3, 1, 3);
    while (cyc < 6) step();
    check("midburst_led2", int'(led[2]), 0);
    do_reset(1);
    check("midburst_rst_led", int'(led), 7);
    check("midburst_rst_done", int'(burst_done), 0);
    while (cyc < 20) begin
      step();
      check("midburst_restart", int'(led), pat030(cyc) ? 7 : 0);
    end

    // half=0 write coinciding with the tick at cycle 3.
    do_reset(1);
    while (cyc < 3) step();
    write(0, 2, 0, 0);
    while (cyc < 28) begin
      check("half0_led0", int'(led[0]), (((cyc - 4) / 4) % 2 == 0) ? 1 : 0);
      check("half0_led1", int'(led[1]), pat030(cyc));
      step();
    end

    // Randomized writes and occasional resets against the model.
    do_reset(1);
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      cfg_valid   = ($urandom_range(0, 2) == 0);
      cfg_ch      = 2'($urandom_range(0, 3));
      cfg_mode    = 2'($urandom_range(0, 3));
      cfg_half_ms = CW'($urandom_range(0, 3));
      cfg_burst   = BW'($urandom_range(0, 3));
      step();
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
